// File: rtl/spin_ctrl.sv
// Wheel-of-fortune spin controller: LFSR-seeded fast spin, linear deceleration, one-hot guess scoring.
// Define SPIN_SCORE_EN to build the saturating 4-bit win counter; otherwise score_o is tied to zero.
`timescale 1ns/1ps
module spin_ctrl #(
    parameter int unsigned PERIOD_INIT = 4,
    parameter int unsigned PERIOD_STEP = 2,
    parameter int unsigned PERIOD_MAX  = 32
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [5:0] guess_i,
    output logic [2:0] pos_o,
    output logic       running_o,
    output logic       done_o,
    output logic       win_o,
    output logic [3:0] score_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SPIN   = 2'd1,
        S_DECEL  = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam logic [7:0] C_PERIOD_INIT = 8'(PERIOD_INIT);
    localparam logic [8:0] C_PERIOD_STEP = 9'(PERIOD_STEP);
    localparam logic [8:0] C_PERIOD_MAX  = 9'(PERIOD_MAX);
    localparam logic [7:0] C_SEED        = 8'hA5;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_lfsr;
    logic [7:0] r_period;
    logic [7:0] r_tick;
    logic [4:0] r_fast;
    logic [5:0] r_guess;
    logic [2:0] r_pos;
    logic       r_done;
    logic       r_win;

    logic       w_lfsr_fb;
    logic       w_moving;
    logic       w_tick_wrap;
    logic [2:0] w_pos_adv;
    logic [8:0] w_period_sum;
    logic       w_stop;
    logic       w_guess_onehot;
    logic       w_win_next;
    logic       w_start_ok;

    assign w_lfsr_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_moving       = (r_state == S_SPIN) || (r_state == S_DECEL);
    assign w_tick_wrap    = w_moving && (r_tick == (r_period - 8'd1));
    assign w_pos_adv      = (r_pos == 3'd5) ? 3'd0 : (r_pos + 3'd1);
    assign w_period_sum   = {1'b0, r_period} + C_PERIOD_STEP;
    assign w_stop         = (r_state == S_DECEL) && w_tick_wrap && (w_period_sum >= C_PERIOD_MAX);
    assign w_start_ok     = start_i && ((r_state == S_IDLE) || (r_state == S_RESULT));

    // x & (x-1) clears the lowest set bit, so it is zero exactly for powers of two.
    assign w_guess_onehot = (r_guess != 6'd0) && ((r_guess & (r_guess - 6'd1)) == 6'd0);
    // The stopping advance lands on w_pos_adv, which is the position the player sees.
    assign w_win_next     = w_guess_onehot && r_guess[w_pos_adv];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_RESULT: begin
                if (start_i) begin
                    w_state_next = S_SPIN;
                end
            end
            S_SPIN: begin
                if (w_tick_wrap && (r_fast == 5'd1)) begin
                    w_state_next = S_DECEL;
                end
            end
            S_DECEL: begin
                if (w_stop) begin
                    w_state_next = S_RESULT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lfsr <= C_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_period <= C_PERIOD_INIT;
            r_tick   <= 8'd0;
            r_fast   <= 5'd0;
            r_guess  <= 6'd0;
            r_pos    <= 3'd0;
            r_done   <= 1'b0;
            r_win    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_period <= C_PERIOD_INIT;
                r_tick   <= 8'd0;
                r_fast   <= 5'd12 + {1'b0, r_lfsr[3:0]};
                r_guess  <= guess_i;
                r_win    <= 1'b0;
            end else if (w_moving) begin
                if (w_tick_wrap) begin
                    r_tick <= 8'd0;
                    r_pos  <= w_pos_adv;
                    if (r_state == S_SPIN) begin
                        r_fast <= r_fast - 5'd1;
                    end else if (w_stop) begin
                        r_period <= C_PERIOD_MAX[7:0];
                        r_done   <= 1'b1;
                        r_win    <= w_win_next;
                    end else begin
                        r_period <= w_period_sum[7:0];
                    end
                end else begin
                    r_tick <= r_tick + 8'd1;
                end
            end
        end
    end

`ifdef SPIN_SCORE_EN
    logic [3:0] r_score;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_score <= 4'd0;
        end else if (w_stop && w_win_next && (r_score != 4'd15)) begin
            r_score <= r_score + 4'd1;
        end
    end

    assign score_o = r_score;
`else
    assign score_o = 4'd0;
`endif

    assign pos_o     = r_pos;
    assign running_o = w_moving;
    assign done_o    = r_done;
    assign win_o     = r_win;

endmodule

// File: tb/tb_spin_ctrl.sv
// Scoreboard bench for spin_ctrl: expected advances and results are queued when a spin is launched.
`timescale 1ns/1ps
module tb_spin_ctrl;

    localparam int PERIOD_INIT = 4;
    localparam int PERIOD_STEP = 2;
    localparam int PERIOD_MAX  = 32;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] guess;
    logic [2:0] pos_o;
    logic       running_o;
    logic       done_o;
    logic       win_o;
    logic [3:0] score_o;

    typedef struct {
        int         interval;
        logic [2:0] pos;
    } adv_t;

    typedef struct {
        logic [2:0] pos;
        logic       win;
        logic [3:0] score;
    } res_t;

    adv_t exp_adv_q[$];
    res_t exp_res_q[$];

    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] m_pos    = 3'd0;
    logic [3:0] m_score  = 4'd0;
    logic [7:0] m_lfsr;

    spin_ctrl #(
        .PERIOD_INIT(PERIOD_INIT),
        .PERIOD_STEP(PERIOD_STEP),
        .PERIOD_MAX (PERIOD_MAX)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .guess_i  (guess),
        .pos_o    (pos_o),
        .running_o(running_o),
        .done_o   (done_o),
        .win_o    (win_o),
        .score_o  (score_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, stepping every clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] next_pos(input logic [2:0] p);
        return (p == 3'd5) ? 3'd0 : 3'(p + 3'd1);
    endfunction

    // gmode: 0 = guess the final position, 1 = empty guess, 2 = two-hot guess
    task automatic run_spin(input int gmode, input bit poke, input bit abort);
        int         n_fast, p, sum, k, last_k, abort_k;
        logic [2:0] pos, prev_pos, start_pos;
        logic [5:0] g;
        logic       w;
        bit         fin;
        adv_t       a;
        res_t       r;

        @(negedge clk);
        n_fast    = 12 + int'(m_lfsr[3:0]);
        start_pos = m_pos;
        p         = PERIOD_INIT;
        pos       = m_pos;
        for (int i = 0; i < n_fast; i++) begin
            pos = next_pos(pos);
            exp_adv_q.push_back('{p, pos});
        end
        while (1) begin
            pos = next_pos(pos);
            exp_adv_q.push_back('{p, pos});
            sum = p + PERIOD_STEP;
            if (sum >= PERIOD_MAX) break;
            p = sum;
        end
        case (gmode)
            0:       g = 6'b000001 << pos;
            1:       g = 6'b000000;
            default: g = 6'b000011;
        endcase
        w = ($countones(g) == 1) && g[pos];
`ifdef SPIN_SCORE_EN
        if (w && m_score != 4'd15) m_score = m_score + 4'd1;
`endif
        r.pos   = pos;
        r.win   = w;
        r.score = m_score;
        exp_res_q.push_back(r);
        m_pos = pos;

        start = 1'b1;
        guess = g;
        @(negedge clk);
        start = 1'b0;
        guess = 6'($urandom);
        chk("spin_running", running_o, 1);
        chk("spin_win_clr", win_o, 0);
        chk("spin_start_pos", pos_o, start_pos);
        prev_pos = pos_o;
        k        = 0;
        last_k   = 0;
        fin      = 0;
        abort_k  = abort ? (4 * n_fast + 12) : -1;

        while (!fin && k < 2000) begin
            @(negedge clk);
            k++;
            if (poke) start = (k == 10);
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                chk("abort_outs", {pos_o, running_o, done_o, win_o, score_o}, 0);
                exp_adv_q.delete();
                exp_res_q.delete();
                m_pos   = 3'd0;
                m_score = 4'd0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("post_abort", {pos_o, running_o, done_o, win_o, score_o}, 0);
                end
                return;
            end
            if (pos_o != prev_pos) begin
                chk("adv_pending", exp_adv_q.size() > 0, 1);
                if (exp_adv_q.size() > 0) begin
                    a = exp_adv_q.pop_front();
                    chk("adv_interval", k - last_k, a.interval);
                    chk("adv_pos", pos_o, a.pos);
                end
                last_k   = k;
                prev_pos = pos_o;
            end
            if (done_o) begin
                fin = 1;
                r   = exp_res_q.pop_front();
                chk("res_pos", pos_o, r.pos);
                chk("res_win", win_o, r.win);
                chk("res_score", score_o, r.score);
                chk("res_running", running_o, 0);
                chk("adv_left", exp_adv_q.size(), 0);
            end else begin
                chk("running", running_o, 1);
            end
        end
        chk("spin_done_seen", fin, 1);
        if (fin) begin
            $display("spin from %0d guess %b -> pos %0d win %0d score %0d in %0d clocks",
                     start_pos, g, pos_o, win_o, score_o, k);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("done_pulse", done_o, 0);
                chk("hold_pos", pos_o, r.pos);
                chk("hold_win", win_o, r.win);
                chk("hold_idle", running_o, 0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        guess = 6'd0;
        repeat (3) begin
            @(negedge clk);
            chk("in_reset", {pos_o, running_o, done_o, win_o, score_o}, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_after_reset", {pos_o, running_o, done_o, win_o, score_o}, 0);
        end

        run_spin(0, 1'b0, 1'b0);
        run_spin(1, 1'b0, 1'b0);
        run_spin(2, 1'b0, 1'b0);
        run_spin(0, 1'b1, 1'b0);
        run_spin(0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) run_spin(0, 1'b0, 1'b0);
`ifdef SPIN_SCORE_EN
        chk("score_saturated", score_o, 15);
`else
        chk("score_disabled", score_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spin_ctrl.md
SPIN_CTRL -- requirements
Module: spin_ctrl

Interface
REQ-001 Parameter PERIOD_INIT, default 4, clocks per position step at spin start (range 2..255).
REQ-002 Parameter PERIOD_STEP, default 2, period increment per step while decelerating (range 1..64).
REQ-003 Parameter PERIOD_MAX, default 32, period at or above which the wheel stops (PERIOD_INIT < PERIOD_MAX <= 255).
REQ-004 clk_i  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  synchronous start request, sampled each clock.
REQ-007 guess_i  input  6  one-hot player guess; bit k selects position k.
REQ-008 pos_o  output  3  current wheel position, 0..5; feeds the evaluation datapath as pos_i.
REQ-009 running_o  output  1  high while the wheel moves; feeds the evaluation datapath as running_i.
REQ-010 done_o  output  1  one-cycle pulse on the wheel stopping.
REQ-011 win_o  output  1  result of the last spin, held until the next spin starts.
REQ-012 score_o  output  4  win count (see Configuration).

Function
REQ-013 FSM states IDLE, SPIN, DECEL, RESULT; running_o=1 exactly in SPIN and DECEL.
REQ-014 Free-running 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, shifts every clock in every state.
REQ-015 IDLE or RESULT, start_i=1: next state SPIN; period<=PERIOD_INIT; tick counter<=0; fast-step count<=12+lfsr[3:0]; guess_i latched; win_o<=0.
REQ-016 start_i is ignored in SPIN and DECEL.
REQ-017 Tick counter increments each clock in SPIN/DECEL; when it equals period-1 it clears and pos_o advances by one (5 wraps to 0).
REQ-018 SPIN: each advance decrements fast-step count; the advance that brings it to 0 moves to DECEL.
REQ-019 DECEL: each advance sets period<=period+PERIOD_STEP (9-bit sum, saturating at PERIOD_MAX); if the sum >= PERIOD_MAX the state moves to RESULT in the same cycle instead.
REQ-020 pos_o is frozen in IDLE and RESULT; new spins start from the current pos_o.
REQ-021 Entry to RESULT: done_o=1 for one cycle; win_o<=latched_guess[pos_o] if latched guess is exactly one-hot, else 0.
REQ-022 RESULT holds pos_o, win_o until start_i; no timeout.

Reset
REQ-023 rst_n_i=0 asynchronously forces: state IDLE, pos_o=0, running_o=0, done_o=0, win_o=0, score_o=0, period=PERIOD_INIT, counters 0, latched guess 0, LFSR 8'hA5.
REQ-024 Reset asserted mid-spin aborts immediately; no done_o pulse, score unchanged beyond clearing to 0.
REQ-025 After deassertion the block sits in IDLE until start_i.

Configuration
REQ-026 Macro SPIN_SCORE_EN defined: 4-bit score register increments on each RESULT entry with win, saturating at 15; cleared only by reset.
REQ-027 SPIN_SCORE_EN undefined: no score register; score_o tied to 4'd0; all other behaviour identical.

Verification
REQ-028 Reset with start_i=0 for 20 clocks -> pos_o=0, running_o=0, done_o=0, win_o=0, score_o=0 throughout.
REQ-029 Defaults, start_i one clock -> running_o=1 next clock; pos_o advances every 4 clocks through 1,2,3,4,5,0 wrap.
REQ-030 Defaults, full spin -> fast intervals 4 clocks, then intervals 6,8,...,30 clocks, one final advance, running_o=0 and single done_o pulse the same edge.
REQ-031 guess_i=1<<final pos_o -> win_o=1, score_o=1; repeat with guess_i=6'b000000 or 6'b000011 -> win_o=0, score_o unchanged.
REQ-032 start_i pulsed during SPIN -> no effect; rst_n_i low mid-DECEL -> outputs at reset values asynchronously, no done_o.
REQ-033 SPIN_SCORE_EN defined, 16 winning spins -> score_o saturates at 15; undefined -> score_o=0 after wins.
